// File: rtl/sarray_mem_resp_pkg.sv
// Shared definitions for the systolic-array memory responder slice.
package sarray_mem_resp_pkg;

    localparam int unsigned ADDR_WIDTH         = 64;
    localparam int unsigned SARRAY_LOAD_WIDTH  = 2048;
    localparam int unsigned SARRAY_STORE_WIDTH = 2048;

    // Which channel owned the SRAM port most recently; drives round-robin.
    typedef enum logic {
        GNT_WR = 1'b0,
        GNT_RD = 1'b1
    } grant_e;

    // Pointer width that stays legal (>= 1 bit) for single-entry storage.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/sarray_mem_resp_sync_fifo.sv
// Synchronous FIFO with push/pop/full/empty flags. Head data reads as zero
// whenever the FIFO is empty so downstream sees a clean bus after reset.
module sync_fifo
    import sarray_mem_resp_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned PTR_W = clog2_min1(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_FULL);
    assign o_empty = (r_count == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; only written entries are ever presented.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_pop_data = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/sarray_mem_resp.sv
// Memory-side responder: single-port line SRAM shared by ar reads and aw
// stores, fixed read latency, credit-bounded outstanding reads, in-order
// responses through a small FIFO.
module sarray_mem_resp
    import sarray_mem_resp_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = sarray_mem_resp_pkg::ADDR_WIDTH,
    parameter int unsigned LOAD_WIDTH  = SARRAY_LOAD_WIDTH,
    parameter int unsigned STORE_WIDTH = SARRAY_STORE_WIDTH,
    parameter int unsigned LINE_SHIFT  = 8,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned RD_LAT      = 2,
    parameter int unsigned RESP_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ar_valid_i,
    output logic                   ar_ready_o,
    input  logic [ADDR_WIDTH-1:0]  ar_addr_i,
    output logic                   r_valid_o,
    input  logic                   r_ready_i,
    output logic [LOAD_WIDTH-1:0]  r_data_o,
    input  logic                   aw_valid_i,
    output logic                   aw_ready_o,
    input  logic [ADDR_WIDTH-1:0]  aw_addr_i,
    input  logic [STORE_WIDTH-1:0] aw_data_i
);

    localparam int unsigned IDX_W = clog2_min1(DEPTH);
    localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);
    localparam logic [CNT_W-1:0] CREDITS = CNT_W'(RESP_DEPTH);

    logic [LOAD_WIDTH-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0]      r_outstanding;
    grant_e                r_last_grant;

    logic                  w_rd_req;
    logic                  w_wr_req;
    logic                  w_grant_rd;
    logic                  w_grant_wr;
    logic                  w_ar_hs;
    logic                  w_aw_hs;
    logic                  w_r_hs;
    logic [IDX_W-1:0]      w_rd_idx;
    logic [IDX_W-1:0]      w_wr_idx;
    logic                  w_push;
    logic [LOAD_WIDTH-1:0] w_push_data;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [LOAD_WIDTH-1:0] w_fifo_head;
    logic                  w_unused;

    // Low (intra-line) and high (wrapping) address bits are dropped.
    assign w_rd_idx = ar_addr_i[LINE_SHIFT +: IDX_W];
    assign w_wr_idx = aw_addr_i[LINE_SHIFT +: IDX_W];
    assign w_unused = ^{ar_addr_i, aw_addr_i};

    // Port arbitration: credit-gated read vs store, round-robin on contention.
    always_comb begin
        w_rd_req   = ar_valid_i && (r_outstanding < CREDITS);
        w_wr_req   = aw_valid_i;
        w_grant_rd = 1'b0;
        w_grant_wr = 1'b0;
        if (w_rd_req && w_wr_req) begin
            w_grant_rd = (r_last_grant == GNT_WR);
            w_grant_wr = (r_last_grant == GNT_RD);
        end else begin
            w_grant_rd = w_rd_req;
            w_grant_wr = w_wr_req;
        end
    end

    assign ar_ready_o = w_rd_req & w_grant_rd;
    assign aw_ready_o = w_wr_req & w_grant_wr;
    assign w_ar_hs    = ar_valid_i & ar_ready_o;
    assign w_aw_hs    = aw_valid_i & aw_ready_o;
    assign w_r_hs     = r_valid_o & r_ready_i;

    // Outstanding-read credit counter and round-robin history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outstanding <= '0;
            r_last_grant  <= GNT_WR;
        end else begin
            case ({w_ar_hs, w_r_hs})
                2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase
            if (w_ar_hs) begin
                r_last_grant <= GNT_RD;
            end else if (w_aw_hs) begin
                r_last_grant <= GNT_WR;
            end
        end
    end

    // SRAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_aw_hs) begin
            r_mem[w_wr_idx] <= aw_data_i;
        end
    end

    // The FIFO register supplies the last cycle of latency, so the
    // pipeline itself is RD_LAT-1 stages deep (none for RD_LAT == 1).
    if (RD_LAT == 1) begin : g_lat1
        assign w_push      = w_ar_hs;
        assign w_push_data = r_mem[w_rd_idx];
    end else begin : g_pipe
        logic                  r_pipe_vld  [RD_LAT-1];
        logic [LOAD_WIDTH-1:0] r_pipe_data [RD_LAT-1];

        // Valid shift chain; cleared on reset so in-flight reads are dropped.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int unsigned i = 0; i < RD_LAT - 1; i++) begin
                    r_pipe_vld[i] <= 1'b0;
                end
            end else begin
                r_pipe_vld[0] <= w_ar_hs;
                for (int unsigned i = 1; i < RD_LAT - 1; i++) begin
                    r_pipe_vld[i] <= r_pipe_vld[i-1];
                end
            end
        end

        // Data shift chain; stage 0 is the synchronous SRAM read.
        always_ff @(posedge clk) begin
            if (w_ar_hs) begin
                r_pipe_data[0] <= r_mem[w_rd_idx];
            end
            for (int unsigned i = 1; i < RD_LAT - 1; i++) begin
                r_pipe_data[i] <= r_pipe_data[i-1];
            end
        end

        assign w_push      = r_pipe_vld[RD_LAT-2];
        assign w_push_data = r_pipe_data[RD_LAT-2];
    end

    sync_fifo #(
        .WIDTH (LOAD_WIDTH),
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push & ~w_fifo_full),
        .i_push_data (w_push_data),
        .i_pop       (w_r_hs),
        .o_pop_data  (w_fifo_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    assign r_valid_o = ~w_fifo_empty;
    assign r_data_o  = w_fifo_head;

endmodule

// File: tb/tb_sarray_mem_resp.sv
// Randomized self-checking bench for sarray_mem_resp against a
// transaction-level model (line array + timestamped response queue).
module tb_sarray_mem_resp;

    localparam int AW         = 64;
    localparam int LW         = 2048;
    localparam int LS         = 8;
    localparam int DEPTH      = 256;
    localparam int RD_LAT     = 2;
    localparam int RESP_DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ar_valid_i;
    logic          ar_ready_o;
    logic [AW-1:0] ar_addr_i;
    logic          r_valid_o;
    logic          r_ready_i;
    logic [LW-1:0] r_data_o;
    logic          aw_valid_i;
    logic          aw_ready_o;
    logic [AW-1:0] aw_addr_i;
    logic [LW-1:0] aw_data_i;

    always #5 clk = ~clk;

    sarray_mem_resp #(
        .ADDR_WIDTH  (AW),
        .LOAD_WIDTH  (LW),
        .STORE_WIDTH (LW),
        .LINE_SHIFT  (LS),
        .DEPTH       (DEPTH),
        .RD_LAT      (RD_LAT),
        .RESP_DEPTH  (RESP_DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ar_valid_i (ar_valid_i),
        .ar_ready_o (ar_ready_o),
        .ar_addr_i  (ar_addr_i),
        .r_valid_o  (r_valid_o),
        .r_ready_i  (r_ready_i),
        .r_data_o   (r_data_o),
        .aw_valid_i (aw_valid_i),
        .aw_ready_o (aw_ready_o),
        .aw_addr_i  (aw_addr_i),
        .aw_data_i  (aw_data_i)
    );

    // Reference model state
    typedef struct {
        logic [LW-1:0] data;
        int unsigned   due;
    } resp_t;

    logic [LW-1:0] m_mem [DEPTH];
    resp_t         m_q[$];
    int unsigned   m_cyc;
    bit            m_last_rd;

    int unsigned   n_chk;
    int unsigned   n_fail;

    // Observations from the most recent cycle
    bit            g_ar_hs;
    bit            g_rv;
    logic [LW-1:0] g_rdata;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        int w;
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            w = 0;
            for (int k = 0; k < LW / 32; k++) begin
                if (obs[k*32 +: 32] !== exp[k*32 +: 32]) begin
                    w = k;
                    break;
                end
            end
            $display("FAIL %s: got %h expected %h (32-bit word %0d)",
                     tag, obs[w*32 +: 32], exp[w*32 +: 32], w);
        end
    endtask

    function automatic int line_of(input logic [AW-1:0] a);
        return int'(a[LS +: 8]);
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        return {$urandom, $urandom};
    endfunction

    // One clock cycle: drive, check against the model, advance the model.
    task automatic cycle(input bit arv, input logic [AW-1:0] ara, input bit rrdy,
                         input bit awv, input logic [AW-1:0] awa, input logic [LW-1:0] awd);
        bit rd_req, exp_ar, exp_aw, exp_rv;
        @(negedge clk);
        ar_valid_i = arv;
        ar_addr_i  = ara;
        r_ready_i  = rrdy;
        aw_valid_i = awv;
        aw_addr_i  = awa;
        aw_data_i  = awd;
        #1;
        rd_req = arv && (m_q.size() < RESP_DEPTH);
        exp_ar = rd_req && (!awv || !m_last_rd);
        exp_aw = awv && !exp_ar;
        exp_rv = (m_q.size() > 0) && (m_q[0].due <= m_cyc);
        chk("ar_ready", ar_ready_o, exp_ar);
        chk("aw_ready", aw_ready_o, exp_aw);
        chk("r_valid", r_valid_o, exp_rv);
        if (exp_rv) chk("r_data", r_data_o, m_q[0].data);
        g_ar_hs = arv && ar_ready_o;
        g_rv    = r_valid_o;
        g_rdata = r_data_o;
        if (exp_rv && rrdy) void'(m_q.pop_front());
        if (exp_ar) begin
            m_q.push_back('{data: m_mem[line_of(ara)], due: m_cyc + RD_LAT});
            m_last_rd = 1'b1;
        end
        if (exp_aw) begin
            m_mem[line_of(awa)] = awd;
            m_last_rd = 1'b0;
        end
        m_cyc++;
    endtask

    task automatic idle(input int n, input bit rrdy);
        for (int k = 0; k < n; k++) cycle(1'b0, '0, rrdy, 1'b0, '0, '0);
    endtask

    // Asynchronous reset pulse; memory contents are kept by both sides.
    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        ar_valid_i = 1'b0;
        aw_valid_i = 1'b0;
        r_ready_i  = 1'b0;
        #1;
        chk("rst_r_valid", r_valid_o, 1'b0);
        chk("rst_r_data", r_data_o, '0);
        m_q.delete();
        m_last_rd = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Continuous ar stream with r_ready low: credits must cap at RESP_DEPTH.
    task automatic credit_stall(input string tag);
        int hs;
        bit have;
        logic [LW-1:0] held;
        hs   = 0;
        have = 1'b0;
        held = '0;
        for (int k = 0; k < 10; k++) begin
            cycle(1'b1, AW'(($urandom % DEPTH) << LS), 1'b0, 1'b0, '0, '0);
            if (g_ar_hs) hs++;
            if (g_rv) begin
                if (have) chk({tag, "_data_stable"}, g_rdata, held);
                held = g_rdata;
                have = 1'b1;
            end
        end
        chk({tag, "_ar_count"}, LW'(hs), LW'(RESP_DEPTH));
    endtask

    initial begin
        logic [LW-1:0] a_line;
        int lat;
        int hs;

        n_chk      = 0;
        n_fail     = 0;
        m_cyc      = 0;
        m_last_rd  = 1'b0;
        rst_n      = 1'b0;
        ar_valid_i = 1'b0;
        ar_addr_i  = '0;
        r_ready_i  = 1'b0;
        aw_valid_i = 1'b0;
        aw_addr_i  = '0;
        aw_data_i  = '0;
        #1;
        chk("reset_r_valid", r_valid_o, 1'b0);
        chk("reset_r_data", r_data_o, '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Fill every line so later reads have defined contents.
        for (int i = 0; i < DEPTH; i++)
            cycle(1'b0, '0, 1'b1, 1'b1, AW'(i) << LS, rand_line());

        // Contention straight after reset: read first, then alternate.
        do_reset();
        cycle(1'b1, AW'(32'h500), 1'b1, 1'b1, AW'(32'h700), rand_line());
        chk("first_grant_is_read", ar_ready_o, 1'b1);
        for (int k = 0; k < 7; k++)
            cycle(1'b1, rand_addr(), 1'b1, 1'b1, rand_addr(), rand_line());
        idle(6, 1'b1);

        // Write line 3 then read it back; measure latency.
        a_line = rand_line();
        cycle(1'b0, '0, 1'b1, 1'b1, AW'(32'h300), a_line);
        cycle(1'b1, AW'(32'h300), 1'b1, 1'b0, '0, '0);
        chk("raw_ar_hs", g_ar_hs, 1'b1);
        lat = -1;
        for (int k = 1; k <= 8; k++) begin
            cycle(1'b0, '0, 1'b1, 1'b0, '0, '0);
            if (lat < 0 && g_rv) begin
                lat = k;
                chk("raw_data", g_rdata, a_line);
            end
        end
        chk("read_latency", LW'(lat), LW'(RD_LAT));

        // 64 back-to-back reads, stride one line.
        hs = 0;
        for (int i = 0; i < 64; i++) begin
            cycle(1'b1, AW'(i) << LS, 1'b1, 1'b0, '0, '0);
            if (g_ar_hs) hs++;
        end
        chk("b2b_ar_count", LW'(hs), LW'(64));
        idle(6, 1'b1);

        // Backpressure, then drain and resume.
        credit_stall("bp");
        for (int k = 0; k < 12; k++)
            cycle(1'b1, AW'(($urandom % DEPTH) << LS), 1'b1, 1'b0, '0, '0);
        idle(6, 1'b1);

        // Aliasing: high bits wrap, low bits ignored.
        a_line = rand_line();
        cycle(1'b0, '0, 1'b1, 1'b1, AW'(32'h100), a_line);
        cycle(1'b1, AW'(32'h1011F), 1'b1, 1'b0, '0, '0);
        idle(1, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b0, '0, '0);
        chk("alias_valid", g_rv, 1'b1);
        chk("alias_data", g_rdata, a_line);
        idle(4, 1'b1);

        // Reset with three reads in flight.
        for (int k = 0; k < 3; k++)
            cycle(1'b1, AW'(k) << LS, 1'b0, 1'b0, '0, '0);
        do_reset();
        hs = 0;
        for (int k = 0; k < 6; k++) begin
            cycle(1'b0, '0, 1'b1, 1'b0, '0, '0);
            if (g_rv) hs++;
        end
        chk("no_stale_beats", LW'(hs), '0);
        credit_stall("post_rst");
        idle(8, 1'b1);

        // Random traffic.
        for (int k = 0; k < 3000; k++)
            cycle(($urandom % 4) != 0, rand_addr(), ($urandom % 4) != 0,
                  ($urandom % 3) == 0, rand_addr(), rand_line());
        idle(10, 1'b1);
        chk("drained", LW'(m_q.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
